// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard_if
// Description : Issue, writeback and status bundle for the register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if;
    logic        flush;
    logic        stall;
    logic        issue_valid_0;
    logic        issue_valid_1;
    logic        issue_we_0;
    logic        issue_we_1;
    logic [4:0]  issue_rd_0;
    logic [4:0]  issue_rj_0;
    logic [4:0]  issue_rk_0;
    logic [4:0]  issue_rd_1;
    logic [4:0]  issue_rj_1;
    logic [4:0]  issue_rk_1;
    logic        issue_use_rj_0;
    logic        issue_use_rk_0;
    logic        issue_use_rj_1;
    logic        issue_use_rk_1;
    logic        write_en_0;
    logic        write_en_1;
    logic [4:0]  write_addr_0;
    logic [4:0]  write_addr_1;
    logic        grant_0;
    logic        grant_1;
    logic [31:0] busy_mask;
    logic        sb_error;

    modport master (
        output flush, stall,
        output issue_valid_0, issue_valid_1, issue_we_0, issue_we_1,
        output issue_rd_0, issue_rj_0, issue_rk_0, issue_rd_1, issue_rj_1, issue_rk_1,
        output issue_use_rj_0, issue_use_rk_0, issue_use_rj_1, issue_use_rk_1,
        output write_en_0, write_en_1, write_addr_0, write_addr_1,
        input  grant_0, grant_1, busy_mask, sb_error
    );

    modport slave (
        input  flush, stall,
        input  issue_valid_0, issue_valid_1, issue_we_0, issue_we_1,
        input  issue_rd_0, issue_rj_0, issue_rk_0, issue_rd_1, issue_rj_1, issue_rk_1,
        input  issue_use_rj_0, issue_use_rk_0, issue_use_rj_1, issue_use_rk_1,
        input  write_en_0, write_en_1, write_addr_0, write_addr_1,
        output grant_0, grant_1, busy_mask, sb_error
    );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Dual-issue register scoreboard with 2-bit pending-write counts.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard (
    input  wire logic       clk,
    input  wire logic       rst,
    reg_scoreboard_if.slave sb_io
);
    localparam int NREG = 32;

    logic [NREG-1:0][1:0] cnt_view;
    logic [NREG-1:0]      busy_d;
    logic [NREG-1:0]      under;
    logic [31:0]          busy_mask_q;
    logic                 sb_error_q;
    logic                 sb_error_d;
    logic                 grant_0;
    logic                 grant_1;

    function automatic logic [1:0] wb_hits(input logic [4:0] a,
                                           input logic we0, input logic [4:0] wa0,
                                           input logic we1, input logic [4:0] wa1);
        logic h0;
        logic h1;
        h0 = we0 && (wa0 == a) && (a != 5'd0);
        h1 = we1 && (wa1 == a) && (a != 5'd0);
        return {1'b0, h0} + {1'b0, h1};
    endfunction

    // Count left after this cycle's writebacks; capacity checks use it so a
    // retiring write frees a slot for an issue in the same cycle.
    function automatic logic [1:0] eff_cnt(input logic [1:0] c, input logic [1:0] h);
        return (c > h) ? (c - h) : 2'd0;
    endfunction

    function automatic logic src_ready(input logic u, input logic [4:0] a,
                                       input logic [1:0] c, input logic [1:0] h);
        return !u || (a == 5'd0) || (c == 2'd0) || ((c == 2'd1) && (h != 2'd0));
    endfunction

    logic [1:0] h_rj0, h_rk0, h_rj1, h_rk1, h_rd0, h_rd1;
    logic       rdy0, rdy1, sat0, sat1, raw1, same1;

    always_comb begin
        h_rj0 = wb_hits(sb_io.issue_rj_0, sb_io.write_en_0, sb_io.write_addr_0,
                        sb_io.write_en_1, sb_io.write_addr_1);
        h_rk0 = wb_hits(sb_io.issue_rk_0, sb_io.write_en_0, sb_io.write_addr_0,
                        sb_io.write_en_1, sb_io.write_addr_1);
        h_rj1 = wb_hits(sb_io.issue_rj_1, sb_io.write_en_0, sb_io.write_addr_0,
                        sb_io.write_en_1, sb_io.write_addr_1);
        h_rk1 = wb_hits(sb_io.issue_rk_1, sb_io.write_en_0, sb_io.write_addr_0,
                        sb_io.write_en_1, sb_io.write_addr_1);
        h_rd0 = wb_hits(sb_io.issue_rd_0, sb_io.write_en_0, sb_io.write_addr_0,
                        sb_io.write_en_1, sb_io.write_addr_1);
        h_rd1 = wb_hits(sb_io.issue_rd_1, sb_io.write_en_0, sb_io.write_addr_0,
                        sb_io.write_en_1, sb_io.write_addr_1);

        rdy0 = src_ready(sb_io.issue_use_rj_0, sb_io.issue_rj_0, cnt_view[sb_io.issue_rj_0], h_rj0)
            && src_ready(sb_io.issue_use_rk_0, sb_io.issue_rk_0, cnt_view[sb_io.issue_rk_0], h_rk0);
        rdy1 = src_ready(sb_io.issue_use_rj_1, sb_io.issue_rj_1, cnt_view[sb_io.issue_rj_1], h_rj1)
            && src_ready(sb_io.issue_use_rk_1, sb_io.issue_rk_1, cnt_view[sb_io.issue_rk_1], h_rk1);

        sat0 = sb_io.issue_we_0 && (sb_io.issue_rd_0 != 5'd0)
            && (eff_cnt(cnt_view[sb_io.issue_rd_0], h_rd0) == 2'd3);
        sat1 = sb_io.issue_we_1 && (sb_io.issue_rd_1 != 5'd0)
            && (eff_cnt(cnt_view[sb_io.issue_rd_1], h_rd1) == 2'd3);

        raw1 = sb_io.issue_we_0 && (sb_io.issue_rd_0 != 5'd0)
            && ((sb_io.issue_use_rj_1 && (sb_io.issue_rj_1 == sb_io.issue_rd_0))
             || (sb_io.issue_use_rk_1 && (sb_io.issue_rk_1 == sb_io.issue_rd_0)));
        same1 = sb_io.issue_we_0 && sb_io.issue_we_1 && (sb_io.issue_rd_1 != 5'd0)
             && (sb_io.issue_rd_0 == sb_io.issue_rd_1)
             && (eff_cnt(cnt_view[sb_io.issue_rd_1], h_rd1) >= 2'd2);

        grant_0 = sb_io.issue_valid_0 && !sb_io.stall && !sb_io.flush && !rst && rdy0 && !sat0;
        grant_1 = grant_0 && sb_io.issue_valid_1 && rdy1 && !sat1 && !raw1 && !same1;
    end

    assign cnt_view[0] = 2'b00;
    assign busy_d[0]   = 1'b0;
    assign under[0]    = 1'b0;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
        localparam logic [4:0] IDX = 5'(gi);
        logic [1:0] cnt_q;
        logic [1:0] cnt_d;
        logic [2:0] add;
        logic [2:0] sub;
        logic [2:0] sum;
        logic [2:0] diff;
        logic       und;

        // Flush discards the whole cycle, including writebacks, so it cannot flag underflow.
        always_comb begin
            add   = 3'(grant_0 && sb_io.issue_we_0 && (sb_io.issue_rd_0 == IDX))
                  + 3'(grant_1 && sb_io.issue_we_1 && (sb_io.issue_rd_1 == IDX));
            sub   = 3'(sb_io.write_en_0 && (sb_io.write_addr_0 == IDX))
                  + 3'(sb_io.write_en_1 && (sb_io.write_addr_1 == IDX));
            sum   = {1'b0, cnt_q} + add;
            diff  = sum - sub;
            und   = 1'b0;
            cnt_d = diff[1:0];
            if (sb_io.flush) begin
                cnt_d = 2'b00;
            end else if (sum < sub) begin
                cnt_d = 2'b00;
                und   = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= 2'b00;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_view[gi] = cnt_q;
        assign busy_d[gi]   = (cnt_d != 2'b00);
        assign under[gi]    = und;
    end

    assign sb_error_d = sb_error_q | (|under);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask_q <= '0;
            sb_error_q  <= 1'b0;
        end else begin
            busy_mask_q <= busy_d;
            sb_error_q  <= sb_error_d;
        end
    end

    assign sb_io.grant_0   = grant_0;
    assign sb_io.grant_1   = grant_1;
    assign sb_io.busy_mask = busy_mask_q;
    assign sb_io.sb_error  = sb_error_q;
endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed and randomized checks of reg_scoreboard against a count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   m_cnt [32];
    bit   m_err;
    logic obs_g0, obs_g1;

    reg_scoreboard_if sbif ();

    reg_scoreboard dut (
        .clk   (clk),
        .rst   (rst),
        .sb_io (sbif)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int wb_hits(input logic [4:0] a);
        int h = 0;
        if (a == 5'd0) return 0;
        if (sbif.write_en_0 && sbif.write_addr_0 == a) h++;
        if (sbif.write_en_1 && sbif.write_addr_1 == a) h++;
        return h;
    endfunction

    function automatic int eff(input logic [4:0] a);
        int e = m_cnt[a] - wb_hits(a);
        return (e < 0) ? 0 : e;
    endfunction

    function automatic bit src_ok(input logic u, input logic [4:0] a);
        return !u || a == 5'd0 || m_cnt[a] == 0 || (m_cnt[a] == 1 && wb_hits(a) > 0);
    endfunction

    // An issue may go only if its sources are ready and the resulting count still fits in 0..3.
    task automatic model_grants(output bit g0, output bit g1);
        bit raw;
        int extra;
        g0 = sbif.issue_valid_0 && !sbif.stall && !sbif.flush && !rst
          && src_ok(sbif.issue_use_rj_0, sbif.issue_rj_0)
          && src_ok(sbif.issue_use_rk_0, sbif.issue_rk_0)
          && (!sbif.issue_we_0 || sbif.issue_rd_0 == 5'd0 || eff(sbif.issue_rd_0) + 1 <= 3);
        raw = sbif.issue_we_0 && sbif.issue_rd_0 != 5'd0
           && ((sbif.issue_use_rj_1 && sbif.issue_rj_1 == sbif.issue_rd_0)
            || (sbif.issue_use_rk_1 && sbif.issue_rk_1 == sbif.issue_rd_0));
        extra = (sbif.issue_we_0 && sbif.issue_rd_0 == sbif.issue_rd_1) ? 1 : 0;
        g1 = g0 && sbif.issue_valid_1 && !raw
          && src_ok(sbif.issue_use_rj_1, sbif.issue_rj_1)
          && src_ok(sbif.issue_use_rk_1, sbif.issue_rk_1)
          && (!sbif.issue_we_1 || sbif.issue_rd_1 == 5'd0 || eff(sbif.issue_rd_1) + 1 + extra <= 3);
    endtask

    task automatic model_update(input bit g0, input bit g1);
        for (int i = 1; i < 32; i++) begin
            int s;
            if (rst || sbif.flush) begin
                m_cnt[i] = 0;
            end else begin
                s = m_cnt[i] - wb_hits(5'(i));
                if (g0 && sbif.issue_we_0 && sbif.issue_rd_0 == 5'(i)) s++;
                if (g1 && sbif.issue_we_1 && sbif.issue_rd_1 == 5'(i)) s++;
                if (s < 0) begin
                    s = 0;
                    m_err = 1'b1;
                end
                m_cnt[i] = s;
            end
        end
        if (rst) m_err = 1'b0;
    endtask

    function automatic logic [31:0] exp_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic clear_inputs();
        rst = 1'b0;
        sbif.flush = 1'b0;          sbif.stall = 1'b0;
        sbif.issue_valid_0 = 1'b0;  sbif.issue_valid_1 = 1'b0;
        sbif.issue_we_0 = 1'b0;     sbif.issue_we_1 = 1'b0;
        sbif.issue_rd_0 = '0;       sbif.issue_rj_0 = '0;   sbif.issue_rk_0 = '0;
        sbif.issue_rd_1 = '0;       sbif.issue_rj_1 = '0;   sbif.issue_rk_1 = '0;
        sbif.issue_use_rj_0 = 1'b0; sbif.issue_use_rk_0 = 1'b0;
        sbif.issue_use_rj_1 = 1'b0; sbif.issue_use_rk_1 = 1'b0;
        sbif.write_en_0 = 1'b0;     sbif.write_en_1 = 1'b0;
        sbif.write_addr_0 = '0;     sbif.write_addr_1 = '0;
    endtask

    // Inputs are applied 1 ns after a rising edge; grants are sampled at the falling edge.
    task automatic step();
        bit g0, g1;
        #4;
        model_grants(g0, g1);
        obs_g0 = sbif.grant_0;
        obs_g1 = sbif.grant_1;
        check_val("grant_0", obs_g0, g0);
        check_val("grant_1", obs_g1, g1);
        model_update(g0, g1);
        @(posedge clk);
        #1;
        check_val("busy_mask", sbif.busy_mask, exp_busy());
        check_val("sb_error", sbif.sb_error, m_err);
    endtask

    task automatic issue0(input logic [4:0] rd);
        sbif.issue_valid_0 = 1'b1; sbif.issue_we_0 = 1'b1; sbif.issue_rd_0 = rd;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [4:0] pick_wb();
        int q[$];
        for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) q.push_back(i);
        if (q.size() == 0 || $urandom_range(0, 19) == 0) return 5'($urandom_range(0, 31));
        return 5'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sbif.issue_valid_0 = 1'b1; sbif.issue_valid_1 = 1'b1;
        step();
        check_val("rst_busy", sbif.busy_mask, 32'h0);
        check_val("rst_grant", {31'd0, obs_g0}, 32'd0);

        // RAW on a pending write, then bypass on the writeback cycle
        clear_inputs(); issue0(5'd5); step();
        clear_inputs(); sbif.issue_valid_0 = 1'b1; sbif.issue_use_rj_0 = 1'b1; sbif.issue_rj_0 = 5'd5;
        step();
        check_val("raw_blk_g0", {31'd0, obs_g0}, 32'd0);
        check_val("raw_busy5", {31'd0, sbif.busy_mask[5]}, 32'd1);
        sbif.write_en_0 = 1'b1; sbif.write_addr_0 = 5'd5;
        step();
        check_val("bypass_g0", {31'd0, obs_g0}, 32'd1);
        check_val("bypass_busy5", {31'd0, sbif.busy_mask[5]}, 32'd0);

        // Intra-pair RAW
        clear_inputs(); issue0(5'd7);
        sbif.issue_valid_1 = 1'b1; sbif.issue_use_rk_1 = 1'b1; sbif.issue_rk_1 = 5'd7;
        step();
        check_val("pair_g0", {31'd0, obs_g0}, 32'd1);
        check_val("pair_g1", {31'd0, obs_g1}, 32'd0);
        check_val("pair_busy7", {31'd0, sbif.busy_mask[7]}, 32'd1);
        clear_inputs(); sbif.write_en_1 = 1'b1; sbif.write_addr_1 = 5'd7; step();

        // Counter saturation and release by a same-cycle writeback
        for (int k = 0; k < 3; k++) begin
            clear_inputs(); issue0(5'd3); step();
        end
        clear_inputs(); issue0(5'd3); step();
        check_val("sat_g0", {31'd0, obs_g0}, 32'd0);
        sbif.write_en_0 = 1'b1; sbif.write_addr_0 = 5'd3; step();
        check_val("sat_wb_g0", {31'd0, obs_g0}, 32'd1);

        // Flush with a concurrent issue
        clear_inputs(); rst = 1'b1; step();
        clear_inputs(); issue0(5'd8);
        sbif.issue_valid_1 = 1'b1; sbif.issue_we_1 = 1'b1; sbif.issue_rd_1 = 5'd9; step();
        sbif.issue_rd_0 = 5'd10; sbif.issue_rd_1 = 5'd11; step();
        check_val("pre_flush_busy", sbif.busy_mask, 32'h0000_0F00);
        clear_inputs(); sbif.flush = 1'b1; issue0(5'd9); step();
        check_val("flush_g0", {31'd0, obs_g0}, 32'd0);
        check_val("flush_busy", sbif.busy_mask, 32'h0);

        // Underflow error, double writeback to the same register
        clear_inputs(); sbif.write_en_0 = 1'b1; sbif.write_addr_0 = 5'd12; step();
        check_val("underflow_err", {31'd0, sbif.sb_error}, 32'd1);
        clear_inputs(); issue0(5'd4);
        sbif.issue_valid_1 = 1'b1; sbif.issue_we_1 = 1'b1; sbif.issue_rd_1 = 5'd4; step();
        check_val("dual_rd_g1", {31'd0, obs_g1}, 32'd1);
        clear_inputs();
        sbif.write_en_0 = 1'b1; sbif.write_addr_0 = 5'd4;
        sbif.write_en_1 = 1'b1; sbif.write_addr_1 = 5'd4; step();
        check_val("dual_wb_busy4", {31'd0, sbif.busy_mask[4]}, 32'd0);
        check_val("err_sticky", {31'd0, sbif.sb_error}, 32'd1);

        // Reset mid-operation
        clear_inputs(); issue0(5'd6); step();
        clear_inputs(); rst = 1'b1; issue0(5'd2); sbif.issue_valid_1 = 1'b1; step();
        check_val("midrst_g0", {31'd0, obs_g0}, 32'd0);
        check_val("midrst_busy", sbif.busy_mask, 32'h0);
        check_val("midrst_err", {31'd0, sbif.sb_error}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            rst                 = ($urandom_range(0, 99) == 0);
            sbif.flush          = ($urandom_range(0, 39) == 0);
            sbif.stall          = ($urandom_range(0, 7) == 0);
            sbif.issue_valid_0  = ($urandom_range(0, 3) != 0);
            sbif.issue_valid_1  = ($urandom_range(0, 3) != 0);
            sbif.issue_we_0     = ($urandom_range(0, 3) != 0);
            sbif.issue_we_1     = ($urandom_range(0, 3) != 0);
            sbif.issue_rd_0     = rnd_addr();
            sbif.issue_rj_0     = rnd_addr();
            sbif.issue_rk_0     = rnd_addr();
            sbif.issue_rd_1     = rnd_addr();
            sbif.issue_rj_1     = rnd_addr();
            sbif.issue_rk_1     = rnd_addr();
            sbif.issue_use_rj_0 = 1'($urandom_range(0, 1));
            sbif.issue_use_rk_0 = 1'($urandom_range(0, 1));
            sbif.issue_use_rj_1 = 1'($urandom_range(0, 1));
            sbif.issue_use_rk_1 = 1'($urandom_range(0, 1));
            sbif.write_en_0     = ($urandom_range(0, 2) == 0);
            sbif.write_en_1     = ($urandom_range(0, 2) == 0);
            sbif.write_addr_0   = pick_wb();
            sbif.write_addr_1   = pick_wb();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port flush, input, 1 bit: pipeline flush; discards all in-flight writes.
REQ-004 SHALL have port stall, input, 1 bit: downstream register-file stage stall; no grants while high.
REQ-005 SHALL have ports issue_valid_0 and issue_valid_1, input, 1 bit each: slot 0/1 holds an instruction.
REQ-006 SHALL have ports issue_we_0 and issue_we_1, input, 1 bit each: slot writes a destination.
REQ-007 SHALL have ports issue_rd_0, issue_rj_0, issue_rk_0, issue_rd_1, issue_rj_1, issue_rk_1, input, 5 bits each: destination and source register addresses.
REQ-008 SHALL have ports issue_use_rj_0, issue_use_rk_0, issue_use_rj_1, issue_use_rk_1, input, 1 bit each: source is read from the register file.
REQ-009 SHALL have ports write_en_0, write_en_1, input, 1 bit each, and write_addr_0, write_addr_1, input, 5 bits each: writeback ports, same timing as the register-file write ports.
REQ-010 SHALL have ports grant_0 and grant_1, output, 1 bit each, combinational: slot is issued this cycle.
REQ-011 SHALL have port busy_mask, output, 32 bits, registered: bit i = register i has a pending write.
REQ-012 SHALL have port sb_error, output, 1 bit, registered, sticky: a writeback arrived for a register with no pending write.

Function
REQ-013 SHALL keep one 2-bit pending counter per register 1..31; register 0 has no counter and SHALL always read as ready.
REQ-014 SHALL treat a source as ready when its use bit is 0, its address is 0, its count is 0, or its count is 1 and a write_en_x with matching write_addr_x is asserted this cycle (write-through bypass).
REQ-015 SHALL assert grant_0 = issue_valid_0 & !stall & !flush & !rst & both slot-0 sources ready & !(issue_we_0 & rd_0!=0 & count[rd_0]==3).
REQ-016 SHALL assert grant_1 only when grant_0 is asserted (in-order issue) and all slot-0 conditions apply to slot 1.
REQ-017 SHALL block grant_1 when issue_we_0 & rd_0!=0 and rd_0 equals a used rj_1 or rk_1 (intra-pair RAW).
REQ-018 SHALL block grant_1 when both slots write the same nonzero rd and that count is 2 or more (counter saturation).
REQ-019 SHALL update each count as next = count + (granted issues writing it) - (valid writebacks to it), all within one cycle; both slots writing the same rd add 2.
REQ-020 SHALL count both writebacks when write_en_0 and write_en_1 target the same register.
REQ-021 SHALL ignore issues and writebacks addressed to register 0.
REQ-022 SHALL, on a writeback to a register whose count would go below 0, hold that count at 0 and set sb_error.
REQ-023 SHALL, when flush is high, clear every count at the next edge, ignoring same-cycle issues and writebacks; sb_error is unaffected.
REQ-024 SHALL drive busy_mask from the counts held after each edge; bit 0 is always 0.
REQ-025 SHALL not modify any count while stall is high, except for writeback decrements.

Reset
REQ-026 SHALL, while rst is high at a rising edge, clear all counts, busy_mask and sb_error.
REQ-027 SHALL hold grant_0 and grant_1 at 0 while rst is high.
REQ-028 SHALL give rst priority over flush, issue and writeback when more than one occurs in the same cycle.

Verification
REQ-029 SHALL pass this case: slot 0 issues rd=5, then slot 0 in the next cycle reads rj=5 with no writeback -> grant_0=0 and busy_mask[5]=1. When write_en_0=1 and write_addr_0=5 is asserted -> grant_0=1 in that same cycle, and busy_mask[5]=0 after the edge.
REQ-030 SHALL pass this case: the same cycle holds slot 0 rd=7 with we=1 and slot 1 rk=7 -> grant_0=1, grant_1=0, and count[7]=1 after the edge.
REQ-031 SHALL pass this case: three issues of rd=3 with no writeback -> count[3]=3. A fourth issue writing rd=3 -> grant_0=0. One writeback to register 3 -> the issue is granted in that same cycle.
REQ-032 SHALL pass this case: with busy_mask=0x0000_0F00, assert flush together with an issue of rd=9 -> busy_mask=0 after the edge and grant_0=0 during the flush cycle.
REQ-033 SHALL pass this case: a writeback to register 12 while count[12]=0 -> sb_error=1 and stays 1 until rst. write_en_0=write_en_1=1 with both addresses 4 and count[4]=2 -> count[4]=0.
REQ-034 SHALL pass this case: rst asserted mid-operation with busy_mask nonzero and valid issues -> grants are 0, and busy_mask=0 and sb_error=0 after the edge.
